mem_ctrl_mc: RTL and testbench
==============================

// Module: mem_ctrl_mc
// PURPOSE
// - Parametrised multi-channel successor of the 3-source fuzzing micro-benchmark memory controller.
// - Each of NUM_CH channels assembles BEATS serial beats of BEAT_W bits into one word.
// - A round-robin arbiter drains completed words through one registered valid/ready output port.
// - Exports toggle coverage, a state-tuple coverage map with a running sum, and a 'bug' flag for fuzzer benches.
// PARAMETERS
// - NUM_CH  3  number of input channels, 2..4
// - BEAT_W  2  bits per input beat, >=1
// - BEATS   4  beats per word, 2..7; DATA_W = BEATS*BEAT_W
// - Derived localparams:
//   - ST_W = clog2(BEATS+1)
//   - CH_W = max(1, clog2(NUM_CH))
//   - MAP_W = NUM_CH*ST_W, which must be <= 12 (elaboration error otherwise)
// PORTS
// - clock       in   1               single clock, all logic on posedge
// - reset       in   1               synchronous, active-high
// - meta_reset  in   1               sync; clears coverage map and io_cov_sum only
// - in_valid    in   NUM_CH          per-channel beat valid
// - in_data     in   NUM_CH*BEAT_W   channel c beat at [c*BEAT_W +: BEAT_W]
// - in_ready    out  NUM_CH          channel c accepts beats (state != FULL)
// - out_valid   out  1               output word valid
// - out_ready   in   1               downstream accept
// - out_data    out  DATA_W          assembled word
// - out_ch      out  CH_W            source channel of out_data
// - coverage    out  NUM_CH*(BEATS+2) sticky toggle bits
// - io_cov_sum  out  MAP_W+1         count of distinct state tuples seen
// - bug         out  1               all channels FULL in the same cycle
// BEHAVIOUR
// - Channel state st[c]: 0 = IDLE, k in 1..BEATS-1 = PEND_k (k beats held), BEATS = FULL.
// - IDLE/PEND_k with in_valid: capture beat into data[c][k*BEAT_W +: BEAT_W], then st += 1.
//   - Capture into IDLE zeroes the upper bits.
// - PEND_k with !in_valid: abort to IDLE; the partial word is discarded.
// - IDLE with !in_valid: stay IDLE.
// - FULL: in_valid/in_data ignored; hold until granted.
// - On grant: st[c] -> IDLE next cycle.
// - Output slot is free when !out_valid or (out_valid && out_ready).
// - When the slot is free and any channel is FULL:
//   - grant the first FULL channel scanning rr_ptr, rr_ptr+1, ... (mod NUM_CH);
//   - load out_data/out_ch, set out_valid, rr_ptr <= grant+1 mod NUM_CH.
// - Slot free and no channel FULL: out_valid <= 0.
// - out_valid && !out_ready: out_data/out_ch are held stable; no grant is issued.
// - Latency: last beat accepted at cycle T; FULL at T+1; out_valid at T+2 if the slot is free.
// - Grant and a same-cycle in_valid on that FULL channel: the beat is dropped (in_ready was 0).
// - bug = &(st[c]==FULL), combinational.
// - Reset values:
//   - all st = IDLE, data = 0, rr_ptr = 0;
//   - out_valid = 0, out_data = 0, out_ch = 0;
//   - in_ready = all ones, bug = 0, coverage = 0.
// - reset mid-word or mid-stall: partial and pending words are lost, out_valid drops next cycle.
// - Toggle coverage:
//   - per channel, one sticky bit per state-equality signal (st==0..BEATS) plus in_valid;
//   - a bit sets when the signal differs from its previous-cycle value;
//   - cleared by reset only, not by meta_reset;
//   - packing: channel 0 in the MSBs; within a channel, state 0 first, in_valid last.
// CONFIGURATION
// - MEM_CTRL_MC_COVMAP_EN defined:
//   - reg_state <= {st[NUM_CH-1],...,st[0]} every cycle;
//   - if covmap[reg_state] == 0: set it and io_cov_sum += 1;
//   - meta_reset has priority: map and sum cleared that cycle;
//   - reset does not clear the map or the sum; the map is zero at time 0.
// - MEM_CTRL_MC_COVMAP_EN undefined: no map or reg_state storage; io_cov_sum tied to 0.
// TESTING (defaults NUM_CH=3, BEAT_W=2, BEATS=4, COVMAP_EN defined)
// - ch0 beats 1,2,3,0 on 4 consecutive cycles, out_ready=1
//   -> out_valid 2 cycles after the last beat, out_data=8'h39, out_ch=0, one cycle.
// - ch1 beats 3,3 then in_valid=0 -> st[1] back to IDLE, no output.
//   - Then a full word 0,0,0,1 -> out_data=8'h40.
// - All 3 channels complete the same cycle, out_ready=1 -> bug=1 for one cycle.
//   - Outputs in order ch0, ch1, ch2, out_valid continuous 3 cycles.
// - out_ready=0 for 5 cycles with ch2 FULL and ch0 completing
//   -> out_data stable, in_ready[0]=0 after FULL.
//   - After out_ready=1, ch2 word, then ch0.
// - Reset only: io_cov_sum=1 after 2 cycles.
//   - Run the ch0 word -> io_cov_sum=5.
//   - meta_reset pulse -> io_cov_sum=0, then 1 on the next cycle.
// - reset asserted while ch1 is in PEND_2 and out_valid=1 -> next cycle all outputs at reset values.
//   - coverage=0, io_cov_sum unchanged.

Source files
------------

// File: rtl/mem_ctrl_mc.sv
// mem_ctrl_mc: multi-channel beat assembler with a round-robin drain onto one registered
// valid/ready port. Exports sticky toggle coverage and a fuzzer 'bug' flag.
// Optional state-tuple coverage map enabled by defining MEM_CTRL_MC_COVMAP_EN.
module mem_ctrl_mc #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned BEAT_W = 2,
  parameter int unsigned BEATS  = 4,
  localparam int unsigned DATA_W = BEATS * BEAT_W,
  localparam int unsigned ST_W   = $clog2(BEATS + 1),
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned MAP_W  = NUM_CH * ST_W,
  localparam int unsigned GRP_W  = BEATS + 2,
  localparam int unsigned COV_W  = NUM_CH * GRP_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       meta_reset,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*BEAT_W-1:0]   in_data,
  output logic [NUM_CH-1:0]          in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [CH_W-1:0]            out_ch,
  output logic [COV_W-1:0]           coverage,
  output logic [MAP_W:0]             io_cov_sum,
  output logic                       bug
);

  if (MAP_W > 12) begin : gen_map_w_check
    $error("mem_ctrl_mc: NUM_CH*ST_W exceeds 12");
  end

  localparam logic [ST_W-1:0] StIdle = '0;
  localparam logic [ST_W-1:0] StFull = ST_W'(BEATS);

  logic [ST_W-1:0]   st_q   [NUM_CH];
  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [BEAT_W-1:0] beat   [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] grant_oh;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   cand;
  logic              grant_valid;
  logic              slot_free;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [COV_W-1:0]  cov_q, cov_prev_q, cov_sig, cov_idle;

  for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
    assign beat[c]     = in_data[c*BEAT_W +: BEAT_W];
    assign full[c]     = (st_q[c] == StFull);
    assign grant_oh[c] = grant_valid && slot_free && (grant_idx == CH_W'(c));
  end

  assign in_ready  = ~full;
  assign bug       = &full;
  assign slot_free = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign coverage  = cov_q;

  // Round-robin search for the first FULL channel starting at rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((32'(rr_ptr_q) + i) % NUM_CH);
      if (!grant_valid && full[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Per-channel beat assembly; a missing beat mid-word aborts back to idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= StIdle;
        data_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (st_q[c] == StFull) begin
          if (grant_oh[c]) st_q[c] <= StIdle;
        end else if (in_valid[c]) begin
          if (st_q[c] == StIdle) data_q[c] <= DATA_W'(beat[c]);
          else data_q[c][st_q[c]*BEAT_W +: BEAT_W] <= beat[c];
          st_q[c] <= st_q[c] + 1'b1;
        end else begin
          st_q[c] <= StIdle;
        end
      end
    end
  end

  // Output slot: load a granted word when free, hold while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else if (slot_free) begin
      if (grant_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= data_q[grant_idx];
        out_ch_q    <= grant_idx;
        rr_ptr_q    <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Toggle signals packed channel 0 in the MSBs, state 0 first, in_valid last.
  always_comb begin
    cov_sig  = '0;
    cov_idle = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned s = 0; s <= BEATS; s++) begin
        cov_sig[(NUM_CH-1-c)*GRP_W + (GRP_W-1-s)] = (st_q[c] == ST_W'(s));
      end
      cov_sig[(NUM_CH-1-c)*GRP_W]                = in_valid[c];
      cov_idle[(NUM_CH-1-c)*GRP_W + (GRP_W-1)]   = 1'b1;
    end
  end

  // Sticky toggle capture; previous values restart at the idle pattern on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cov_q      <= '0;
      cov_prev_q <= cov_idle;
    end else begin
      cov_q      <= cov_q | (cov_sig ^ cov_prev_q);
      cov_prev_q <= cov_sig;
    end
  end

`ifdef MEM_CTRL_MC_COVMAP_EN
  // Map contents survive reset; only meta_reset clears them.
  logic [MAP_W-1:0]        state_tuple;
  logic [MAP_W-1:0]        reg_state_q = '0;
  logic [(2**MAP_W)-1:0]   covmap_q    = '0;
  logic [MAP_W:0]          cov_sum_q   = '0;

  // Concatenate channel states, channel 0 in the LSBs.
  always_comb begin
    state_tuple = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_tuple[c*ST_W +: ST_W] = st_q[c];
    end
  end

  // Count each distinct registered state tuple once.
  always_ff @(posedge clock) begin
    reg_state_q <= state_tuple;
    if (meta_reset) begin
      covmap_q  <= '0;
      cov_sum_q <= '0;
    end else if (!covmap_q[reg_state_q]) begin
      covmap_q[reg_state_q] <= 1'b1;
      cov_sum_q             <= cov_sum_q + 1'b1;
    end
  end

  assign io_cov_sum = cov_sum_q;
`else
  logic unused_meta_reset;
  assign unused_meta_reset = meta_reset;
  assign io_cov_sum        = '0;
`endif

endmodule

// File: tb/tb_mem_ctrl_mc.sv
// Directed self-checking bench for mem_ctrl_mc at default parameters.
module tb_mem_ctrl_mc;

`ifdef MEM_CTRL_MC_COVMAP_EN
  localparam bit CovEn = 1'b1;
`else
  localparam bit CovEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        meta_reset;
  logic [2:0]  in_valid;
  logic [5:0]  in_data;
  logic [2:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic [17:0] coverage;
  logic [9:0]  io_cov_sum;
  logic        bug;

  int tests = 0;
  int fails = 0;

  mem_ctrl_mc dut (
    .clock      (clock),
    .reset      (reset),
    .meta_reset (meta_reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .coverage   (coverage),
    .io_cov_sum (io_cov_sum),
    .bug        (bug)
  );

  always #5 clock = ~clock;

  // Advance n edges; inputs and samples both sit 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; meta_reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
    step(2);
    meta_reset = 1'b0;
    step(2);
    tests++; if (in_ready !== 3'b111) begin fails++; $display("FAIL rst_in_ready got %b want 111", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data got %h want 00", out_data); end
    tests++; if (out_ch !== 2'd0) begin fails++; $display("FAIL rst_out_ch got %0d want 0", out_ch); end
    tests++; if (bug !== 1'b0) begin fails++; $display("FAIL rst_bug got %b want 0", bug); end
    tests++; if (coverage !== 18'h0) begin fails++; $display("FAIL rst_coverage got %h want 0", coverage); end
    tests++; if (io_cov_sum !== (CovEn ? 10'd1 : 10'd0)) begin
      fails++; $display("FAIL rst_cov_sum got %0d want %0d", io_cov_sum, CovEn ? 1 : 0);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_basic_word();
    logic [1:0] beats [4];
    beats[0] = 2'd1; beats[1] = 2'd2; beats[2] = 2'd3; beats[3] = 2'd0;
    out_ready = 1'b1;
    in_valid  = 3'b001;
    for (int j = 0; j < 4; j++) begin
      in_data = {4'b0000, beats[j]};
      step(1);
    end
    in_valid = '0;
    tests++; if (in_ready !== 3'b110) begin fails++; $display("FAIL basic_full_ready got %b want 110", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    step(1);
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h39 || out_ch !== 2'd0) begin
      fails++; $display("FAIL basic_word got v=%b d=%h ch=%0d want v=1 d=39 ch=0", out_valid, out_data, out_ch);
    end
    tests++; if (in_ready !== 3'b111) begin fails++; $display("FAIL basic_idle_ready got %b want 111", in_ready); end
    step(1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle got %b want 0", out_valid); end
    step(2);
    tests++; if (io_cov_sum !== (CovEn ? 10'd5 : 10'd0)) begin
      fails++; $display("FAIL basic_cov_sum got %0d want %0d", io_cov_sum, CovEn ? 5 : 0);
    end
    tests++; if (coverage !== 18'h3F000) begin fails++; $display("FAIL basic_coverage got %h want 3f000", coverage); end
  endtask

  task automatic test_meta_reset();
    meta_reset = 1'b1;
    step(1);
    meta_reset = 1'b0;
    tests++; if (io_cov_sum !== 10'd0) begin fails++; $display("FAIL meta_clear got %0d want 0", io_cov_sum); end
    step(1);
    tests++; if (io_cov_sum !== (CovEn ? 10'd1 : 10'd0)) begin
      fails++; $display("FAIL meta_recount got %0d want %0d", io_cov_sum, CovEn ? 1 : 0);
    end
  endtask

  task automatic test_abort();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 3'b010;
    in_data   = 6'b00_11_00;
    step(2);
    in_valid = '0;
    step(3);
    tests++; if (out_valid !== 1'b0 || in_ready !== 3'b111) begin
      fails++; $display("FAIL abort_idle got v=%b rdy=%b want v=0 rdy=111", out_valid, in_ready);
    end
    tests++; if (coverage !== 18'h00E40) begin fails++; $display("FAIL abort_coverage got %h want 00e40", coverage); end
    in_valid = 3'b010;
    in_data  = 6'b00_00_00;
    step(3);
    in_data = 6'b00_01_00;
    step(1);
    in_valid = '0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_early_valid got %b want 0", out_valid); end
    step(1);
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h40 || out_ch !== 2'd1) begin
      fails++; $display("FAIL abort_word got v=%b d=%h ch=%0d want v=1 d=40 ch=1", out_valid, out_data, out_ch);
    end
    step(1);
  endtask

  task automatic test_all_full();
    logic [5:0] vec [4];
    logic [7:0] exp_d [3];
    vec[0] = 6'b11_00_01; vec[1] = 6'b10_00_10; vec[2] = 6'b01_00_11; vec[3] = 6'b00_01_00;
    exp_d[0] = 8'h39; exp_d[1] = 8'h40; exp_d[2] = 8'h1B;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 3'b111;
    for (int j = 0; j < 4; j++) begin
      in_data = vec[j];
      step(1);
    end
    in_valid = '0;
    tests++; if (bug !== 1'b1) begin fails++; $display("FAIL allfull_bug got %b want 1", bug); end
    tests++; if (in_ready !== 3'b000) begin fails++; $display("FAIL allfull_ready got %b want 000", in_ready); end
    for (int k = 0; k < 3; k++) begin
      step(1);
      tests++; if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_ch !== 2'(k)) begin
        fails++;
        $display("FAIL allfull_word%0d got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                 k, out_valid, out_data, out_ch, exp_d[k], k);
      end
      if (k == 0) begin
        tests++; if (bug !== 1'b0) begin fails++; $display("FAIL allfull_bug_drop got %b want 0", bug); end
      end
    end
    step(1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL allfull_end got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    logic [1:0] b2 [4];
    logic [1:0] b0 [4];
    b2[0] = 2'd3; b2[1] = 2'd2; b2[2] = 2'd1; b2[3] = 2'd0;
    b0[0] = 2'd1; b0[1] = 2'd2; b0[2] = 2'd3; b0[3] = 2'd0;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 3'b100;
    for (int j = 0; j < 4; j++) begin
      in_data = {b2[j], 4'b0000};
      step(1);
    end
    in_valid = '0;
    step(1);
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h1B || out_ch !== 2'd2) begin
      fails++; $display("FAIL stall_first got v=%b d=%h ch=%0d want v=1 d=1b ch=2", out_valid, out_data, out_ch);
    end
    in_valid = 3'b001;
    for (int j = 0; j < 4; j++) begin
      in_data = {4'b0000, b0[j]};
      step(1);
    end
    in_valid = '0;
    for (int k = 0; k < 5; k++) begin
      tests++; if (out_valid !== 1'b1 || out_data !== 8'h1B || out_ch !== 2'd2 || in_ready[0] !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold%0d got v=%b d=%h ch=%0d rdy0=%b want v=1 d=1b ch=2 rdy0=0",
                 k, out_valid, out_data, out_ch, in_ready[0]);
      end
      step(1);
    end
    out_ready = 1'b1;
    in_valid  = 3'b001;
    in_data   = 6'b00_00_11;
    step(1);
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h39 || out_ch !== 2'd0) begin
      fails++; $display("FAIL stall_second got v=%b d=%h ch=%0d want v=1 d=39 ch=0", out_valid, out_data, out_ch);
    end
    // The beat offered during the grant is dropped, so three more beats never complete a word.
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 3) ? 3'b001 : 3'b000;
      in_data  = 6'b00_00_10;
      step(1);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_drop%0d got %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] b0 [4];
    b0[0] = 2'd1; b0[1] = 2'd2; b0[2] = 2'd3; b0[3] = 2'd0;
    reset = 1'b1; meta_reset = 1'b1; in_valid = '0;
    step(2);
    reset = 1'b0; meta_reset = 1'b0; out_ready = 1'b0;
    in_valid = 3'b001;
    for (int j = 0; j < 4; j++) begin
      in_data = {4'b0000, b0[j]};
      step(1);
    end
    in_valid = '0;
    step(2);
    in_valid = 3'b010;
    in_data  = 6'b00_01_00;
    step(2);
    tests++; if (out_valid !== 1'b1 || in_ready !== 3'b111) begin
      fails++; $display("FAIL mid_pre got v=%b rdy=%b want v=1 rdy=111", out_valid, in_ready);
    end
    reset    = 1'b1;
    in_valid = '0;
    step(1);
    tests++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      fails++; $display("FAIL mid_out got v=%b d=%h ch=%0d want v=0 d=00 ch=0", out_valid, out_data, out_ch);
    end
    tests++; if (in_ready !== 3'b111 || bug !== 1'b0) begin
      fails++; $display("FAIL mid_ready got rdy=%b bug=%b want rdy=111 bug=0", in_ready, bug);
    end
    tests++; if (coverage !== 18'h0) begin fails++; $display("FAIL mid_coverage got %h want 0", coverage); end
    tests++; if (io_cov_sum !== (CovEn ? 10'd6 : 10'd0)) begin
      fails++; $display("FAIL mid_cov_sum got %0d want %0d", io_cov_sum, CovEn ? 6 : 0);
    end
    step(2);
    tests++; if (io_cov_sum !== (CovEn ? 10'd7 : 10'd0)) begin
      fails++; $display("FAIL mid_cov_sum_late got %0d want %0d", io_cov_sum, CovEn ? 7 : 0);
    end
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_meta_reset();
    test_abort();
    test_all_full();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
